free_tag_release_queue: RTL and testbench

//  Writer end of the integer free-tag list: gathers physical tags freed at commit (up to 2/cycle),

---
 rtl/free_tag_release_queue.sv | 97 +++++++++
 tb/tb_free_tag_release_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/free_tag_release_queue.sv
// Writer end of the integer free-tag list: stages tags freed at commit and drains them one per cycle.
// Optional FREE_TAG_BYPASS_EN: a tag released into an empty, writable queue goes straight to Din.
module free_tag_release_queue #(
  parameter int TAGWIDE = 5,
  parameter int STGDEEP = 4
) (
  input  logic                       Clk,
  input  logic                       Rest,
  input  logic                       Rel0Valid,
  input  logic [TAGWIDE-1:0]         Rel0Tag,
  input  logic                       Rel1Valid,
  input  logic [TAGWIDE-1:0]         Rel1Tag,
  output logic                       RelReady,
  input  logic                       CriqFull,
  input  logic                       CriqClean,
  output logic                       Wable,
  output logic [TAGWIDE-1:0]         Din,
  output logic                       RelOvf,
  output logic [$clog2(STGDEEP):0]   StgCount
);

  localparam int PW = $clog2(STGDEEP);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(STGDEEP);

  logic [TAGWIDE-1:0] r_mem [STGDEEP];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               r_ovf;

  logic          w_push0, w_push1;
  logic          w_byp0, w_byp1;
  logic          w_st0, w_st1;
  logic          w_acc0, w_acc1;
  logic          w_pop;
  logic [CW-1:0] w_free;

  // Tag 0 is the hardwired zero register and never goes back to the list.
  assign w_push0 = Rel0Valid && (Rel0Tag != '0);
  assign w_push1 = Rel1Valid && (Rel1Tag != '0);

  assign w_free   = DEPTH - r_count;
  assign RelReady = (w_free >= CW'(2));
  assign w_pop    = (r_count != '0) && !CriqFull && !CriqClean;

`ifdef FREE_TAG_BYPASS_EN
  logic w_byp_ok;
  assign w_byp_ok = (r_count == '0) && !CriqFull && !CriqClean;
  assign w_byp0   = w_byp_ok && w_push0;
  assign w_byp1   = w_byp_ok && !w_push0 && w_push1;
  assign Wable    = w_pop || w_byp0 || w_byp1;
  assign Din      = (r_count != '0) ? r_mem[r_head] :
                    w_byp0          ? Rel0Tag       :
                    w_byp1          ? Rel1Tag       : '0;
`else
  assign w_byp0 = 1'b0;
  assign w_byp1 = 1'b0;
  assign Wable  = w_pop;
  assign Din    = (r_count != '0) ? r_mem[r_head] : '0;
`endif

  // Space is judged on the registered count only; excess pushes are dropped, older lane first.
  assign w_st0  = w_push0 && !w_byp0;
  assign w_st1  = w_push1 && !w_byp1;
  assign w_acc0 = w_st0 && (w_free >= CW'(1));
  assign w_acc1 = w_st1 && (w_free >= (w_acc0 ? CW'(2) : CW'(1)));

  assign RelOvf   = r_ovf;
  assign StgCount = r_count;

  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if ((w_push0 || w_push1) && !RelReady)
        r_ovf <= 1'b1;
      if (CriqClean) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_acc0)
          r_mem[r_tail] <= Rel0Tag;
        if (w_acc1)
          r_mem[r_tail + PW'(w_acc0)] <= Rel1Tag;
        r_tail  <= r_tail + PW'(w_acc0) + PW'(w_acc1);
        r_head  <= r_head + PW'(w_pop);
        r_count <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_free_tag_release_queue.sv
// Directed bench for free_tag_release_queue: hand-computed vectors for staging, drain, overflow and clean.
module tb_free_tag_release_queue;

  logic       Clk = 1'b0;
  logic       Rest;
  logic       Rel0Valid, Rel1Valid;
  logic [4:0] Rel0Tag, Rel1Tag;
  logic       RelReady;
  logic       CriqFull, CriqClean;
  logic       Wable;
  logic [4:0] Din;
  logic       RelOvf;
  logic [2:0] StgCount;

  int checks = 0;
  int errors = 0;

  free_tag_release_queue #(.TAGWIDE(5), .STGDEEP(4)) dut (
    .Clk(Clk), .Rest(Rest),
    .Rel0Valid(Rel0Valid), .Rel0Tag(Rel0Tag),
    .Rel1Valid(Rel1Valid), .Rel1Tag(Rel1Tag),
    .RelReady(RelReady), .CriqFull(CriqFull), .CriqClean(CriqClean),
    .Wable(Wable), .Din(Din), .RelOvf(RelOvf), .StgCount(StgCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 after the edge; outputs are sampled 1 later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rel(input logic v0, input logic [4:0] t0, input logic v1, input logic [4:0] t1);
    Rel0Valid = v0; Rel0Tag = t0;
    Rel1Valid = v1; Rel1Tag = t1;
    #1;
  endtask

  initial begin
    Rest = 1'b1; CriqFull = 1'b0; CriqClean = 1'b0;
    Rel0Valid = 1'b0; Rel0Tag = '0; Rel1Valid = 1'b0; Rel1Tag = '0;
    tick(); tick();
    #1;
    check("rst_wable", Wable, 0);
    check("rst_din", Din, 0);
    check("rst_ready", RelReady, 1);
    check("rst_count", StgCount, 0);
    check("rst_ovf", RelOvf, 0);
    Rest = 1'b0;
    tick();

    // Pair 7,9 into an empty queue.
    rel(1, 5'd7, 1, 5'd9);
`ifdef FREE_TAG_BYPASS_EN
    check("t2_byp_wable", Wable, 1);
    check("t2_byp_din", Din, 7);
    tick(); rel(0, 0, 0, 0);
    check("t2_cnt1", StgCount, 1);
    check("t2_din9", Din, 9);
    check("t2_wable9", Wable, 1);
`else
    check("t2_no_bypass", Wable, 0);
    tick(); rel(0, 0, 0, 0);
    check("t2_cnt2", StgCount, 2);
    check("t2_din7", Din, 7);
    check("t2_wable7", Wable, 1);
    tick();
    check("t2_din9", Din, 9);
    check("t2_wable9", Wable, 1);
`endif
    tick();
    check("t2_idle", Wable, 0);
    check("t2_cnt0", StgCount, 0);

    // Tag 0 on lane 0 is filtered.
    rel(1, 5'd0, 1, 5'd12);
`ifdef FREE_TAG_BYPASS_EN
    check("t3_byp_din", Din, 12);
    check("t3_byp_wable", Wable, 1);
    tick(); rel(0, 0, 0, 0);
`else
    check("t3_no_bypass", Wable, 0);
    tick(); rel(0, 0, 0, 0);
    check("t3_cnt1", StgCount, 1);
    check("t3_din12", Din, 12);
    check("t3_wable", Wable, 1);
    tick();
`endif
    check("t3_cnt0", StgCount, 0);
    check("t3_idle", Wable, 0);

    // Back-pressure: fill to 4 while the free list is full.
    CriqFull = 1'b1;
    rel(1, 5'd3, 1, 5'd4);
    tick();
    check("t4_cnt2", StgCount, 2);
    check("t4_ready2", RelReady, 1);
    check("t4_held", Wable, 0);
    rel(1, 5'd5, 1, 5'd6);
    tick(); rel(0, 0, 0, 0);
    check("t4_cnt4", StgCount, 4);
    check("t4_ready4", RelReady, 0);
    check("t4_ovf_clear", RelOvf, 0);

    // Release while full: dropped, sticky overflow.
    rel(1, 5'd14, 0, 0);
    tick(); rel(0, 0, 0, 0);
    check("t6_ovf", RelOvf, 1);
    check("t6_cnt4", StgCount, 4);

    CriqFull = 1'b0;
    #1;
    check("t4_d3", Din, 3);
    check("t4_w3", Wable, 1);
    tick();
    check("t4_d4", Din, 4);
    tick();
    check("t4_d5", Din, 5);
    tick();
    check("t4_d6", Din, 6);
    check("t4_w6", Wable, 1);
    tick();
    check("t4_empty", Wable, 0);
    check("t4_cnt0", StgCount, 0);
    check("t6_sticky", RelOvf, 1);

    // Clean with three staged and a same-cycle push.
    CriqFull = 1'b1;
    rel(1, 5'd2, 1, 5'd3);
    tick();
    rel(1, 5'd4, 0, 0);
    tick();
    check("t5_cnt3", StgCount, 3);
    check("t5_ready3", RelReady, 0);
    CriqFull = 1'b0; CriqClean = 1'b1;
    rel(1, 5'd11, 0, 0);
    check("t5_clean_wable", Wable, 0);
    tick();
    CriqClean = 1'b0;
    rel(0, 0, 0, 0);
    check("t5_cnt0", StgCount, 0);
    check("t5_wable0", Wable, 0);
    check("t5_din0", Din, 0);

    // Reset mid-operation.
    CriqFull = 1'b1;
    rel(1, 5'd5, 0, 0);
    tick(); rel(0, 0, 0, 0);
    check("rst2_pre", StgCount, 1);
    Rest = 1'b1;
    rel(1, 5'd6, 1, 5'd7);
    tick();
    Rest = 1'b0; CriqFull = 1'b0;
    rel(0, 0, 0, 0);
    check("rst2_cnt", StgCount, 0);
    check("rst2_ovf", RelOvf, 0);
    check("rst2_ready", RelReady, 1);
    check("rst2_wable", Wable, 0);

`ifdef FREE_TAG_BYPASS_EN
    rel(1, 5'd8, 0, 0);
    check("byp_din8", Din, 8);
    check("byp_w8", Wable, 1);
    tick(); rel(0, 0, 0, 0);
    check("byp_cnt0", StgCount, 0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
